// File: rtl/dff_bank_arbiter_pkg.sv
// dff_bank_arbiter_pkg: shared state encoding and owner-index width helper
package dff_bank_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;
  function automatic int idw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// dff_bank_arbiter_rr_pick: combinational round-robin picker starting at i_ptr
module dff_bank_arbiter_rr_pick
  import dff_bank_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_any,
  output logic [NREQ-1:0] o_onehot,
  output logic [IDW-1:0]  o_idx
);
  int w_j;
  // scan ptr, ptr+1, ... modulo NREQ and keep the first requester found
  always_comb begin
    o_any = 1'b0;
    o_onehot = '0;
    o_idx = '0;
    w_j = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(i_ptr) + k;
      w_j = (w_j >= NREQ) ? w_j - NREQ : w_j;
      if (!o_any && i_req[w_j]) begin
        o_any = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx = IDW'(w_j);
      end
    end
  end
endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin write arbiter with lockable bursts onto a shared register
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = idw_f(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ-1:0]       i_lock,
  input  logic [NREQ*WIDTH-1:0] i_wdata,
  output logic [NREQ-1:0]       o_gnt,
  output logic [NREQ-1:0]       o_ack,
  output logic [WIDTH-1:0]      o_q,
  output logic                  o_q_valid,
  output logic [IDW-1:0]        o_owner
);
  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic             w_any;
  logic [NREQ-1:0]  w_onehot;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_sel;
  logic [WIDTH-1:0] w_data;
  logic [NREQ-1:0]  w_own_oh;

  dff_bank_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req(i_req),
    .i_ptr(r_ptr),
    .o_any(w_any),
    .o_onehot(w_onehot),
    .o_idx(w_idx)
  );

  function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] i);
    return (i == IDW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign w_sel = (r_state == ST_OWN) ? o_owner : w_idx;
  assign w_data = i_wdata[int'(w_sel)*WIDTH +: WIDTH];
  assign w_own_oh = NREQ'(1) << o_owner;

  // arbitration FSM: one-shot grants in IDLE, held grant during a locked burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr <= '0;
      o_gnt <= '0;
      o_ack <= '0;
      o_q <= '0;
      o_q_valid <= 1'b0;
      o_owner <= '0;
    end else begin
      o_ack <= '0;
      if (r_state == ST_IDLE) begin
        o_gnt <= '0;
        if (w_any) begin
          o_q <= w_data;
          o_ack <= w_onehot;
          o_gnt <= w_onehot;
          o_owner <= w_idx;
          o_q_valid <= 1'b1;
          if (i_lock[w_idx]) r_state <= ST_OWN;
          else r_ptr <= nxt(w_idx);
        end
      end else begin
        if (i_req[o_owner]) begin
          o_q <= w_data;
          o_ack <= w_own_oh;
        end
        if (!i_lock[o_owner]) begin
          r_state <= ST_IDLE;
          r_ptr <= nxt(o_owner);
          o_gnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed and randomized checks of the lockable round-robin arbiter
module tb_dff_bank_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, lock, gnt, ack;
  logic [31:0] wdata;
  logic [7:0] q;
  logic qv;
  logic [1:0] owner;
  int total = 0;
  int bad = 0;

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_lock(lock), .i_wdata(wdata),
    .o_gnt(gnt), .o_ack(ack), .o_q(q), .o_q_valid(qv), .o_owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; lock = '0; wdata = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = '0; lock = '0; wdata = '0; rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL rst0_gnt got=%b exp=0000", gnt); end
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL rst0_ack got=%b exp=0000", ack); end
    total++; if (q !== 8'h00) begin bad++; $display("FAIL rst0_q got=%h exp=00", q); end
    total++; if (qv !== 1'b0) begin bad++; $display("FAIL rst0_qv got=%b exp=0", qv); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL rst0_owner got=%0d exp=0", owner); end
    step();
    rst = 1'b0;
    req = 4'b0010;
    step();
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL rst_pre_ack got=%b exp=0010", ack); end
    req = 4'b0100; lock = 4'b0100; wdata[23:16] = 8'h5A;
    step();
    total++; if (q !== 8'h5A) begin bad++; $display("FAIL rst_burst_q got=%h exp=5a", q); end
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rst_burst_gnt got=%b exp=0100", gnt); end
    #2 rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL rst_mid_gnt got=%b exp=0000", gnt); end
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL rst_mid_ack got=%b exp=0000", ack); end
    total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_mid_q got=%h exp=00", q); end
    total++; if (qv !== 1'b0) begin bad++; $display("FAIL rst_mid_qv got=%b exp=0", qv); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL rst_mid_owner got=%0d exp=0", owner); end
    #1 rst = 1'b0;
    req = 4'b1111; lock = 4'b0; wdata = 32'h13121110;
    step();
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL rst_after_ack got=%b exp=0001", ack); end
    total++; if (q !== 8'h10) begin bad++; $display("FAIL rst_after_q got=%h exp=10", q); end
  endtask

  task automatic test_rotate();
    logic [3:0] e;
    do_reset();
    wdata = 32'h13121110; req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      e = 4'b0001 << k;
      total++; if (ack !== e) begin bad++; $display("FAIL rot_ack%0d got=%b exp=%b", k, ack, e); end
      total++; if (gnt !== e) begin bad++; $display("FAIL rot_gnt%0d got=%b exp=%b", k, gnt, e); end
      total++; if (q !== 8'(16 + k)) begin bad++; $display("FAIL rot_q%0d got=%h exp=%h", k, q, 8'(16 + k)); end
      total++; if (owner !== 2'(k)) begin bad++; $display("FAIL rot_owner%0d got=%0d exp=%0d", k, owner, k); end
    end
  endtask

  task automatic test_sparse();
    do_reset();
    wdata = 32'hD3C2B1A0; req = 4'b1010;
    step();
    total++; if (ack !== 4'b0010 || q !== 8'hB1) begin bad++; $display("FAIL sparse1 got=%b/%h exp=0010/b1", ack, q); end
    step();
    total++; if (ack !== 4'b1000 || q !== 8'hD3) begin bad++; $display("FAIL sparse3 got=%b/%h exp=1000/d3", ack, q); end
    step();
    total++; if (ack !== 4'b0010 || q !== 8'hB1) begin bad++; $display("FAIL sparse_wrap got=%b/%h exp=0010/b1", ack, q); end
  endtask

  task automatic test_lock_burst();
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b0101; lock = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wdata = {8'h33, 8'(8'hC0 + k), 8'h11, 8'hA0};
      step();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL burst_gnt%0d got=%b exp=0100", k, gnt); end
      total++; if (ack !== 4'b0100) begin bad++; $display("FAIL burst_ack%0d got=%b exp=0100", k, ack); end
      total++; if (q !== 8'(8'hC0 + k)) begin bad++; $display("FAIL burst_q%0d got=%h exp=%h", k, q, 8'(8'hC0 + k)); end
    end
    req = 4'b0001; lock = 4'b0;
    step();
    total++; if (ack !== 4'b0 || gnt !== 4'b0) begin bad++; $display("FAIL release got=%b/%b exp=0000/0000", ack, gnt); end
    total++; if (q !== 8'hC2) begin bad++; $display("FAIL release_q got=%h exp=c2", q); end
    step();
    total++; if (ack !== 4'b0001 || gnt !== 4'b0001) begin bad++; $display("FAIL after_rel got=%b/%b exp=0001/0001", ack, gnt); end
    total++; if (q !== 8'hA0 || owner !== 2'd0) begin bad++; $display("FAIL after_rel_q got=%h/%0d exp=a0/0", q, owner); end
  endtask

  task automatic test_own_idle();
    do_reset();
    wdata = 32'h00007700; req = 4'b0010; lock = 4'b0010;
    step();
    total++; if (q !== 8'h77 || gnt !== 4'b0010) begin bad++; $display("FAIL own_start got=%h/%b exp=77/0010", q, gnt); end
    req = 4'b0001; lock = 4'b0011; wdata = 32'h00008855;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (q !== 8'h77) begin bad++; $display("FAIL own_idle_q%0d got=%h exp=77", k, q); end
      total++; if (ack !== 4'b0) begin bad++; $display("FAIL own_idle_ack%0d got=%b exp=0000", k, ack); end
      total++; if (gnt !== 4'b0010 || owner !== 2'd1) begin bad++; $display("FAIL own_idle_gnt%0d got=%b/%0d exp=0010/1", k, gnt, owner); end
    end
    req = 4'b0; lock = 4'b0;
    step();
    total++; if (gnt !== 4'b0 || q !== 8'h77 || qv !== 1'b1) begin bad++; $display("FAIL own_end got=%b/%h/%b exp=0000/77/1", gnt, q, qv); end
  endtask

  task automatic test_random();
    logic [3:0] m_gnt, m_ack, req_pre;
    logic [7:0] m_q;
    logic m_qv, m_st, st_pre, found;
    int m_ptr, m_owner, w, j, wmax;
    int wt[4];
    do_reset();
    m_gnt = '0; m_q = '0; m_qv = 1'b0; m_st = 1'b0; m_ptr = 0; m_owner = 0; w = 0;
    for (int i = 0; i < 4; i++) wt[i] = 0;
    for (int n = 0; n < 2000; n++) begin
      req = 4'($urandom); lock = 4'($urandom & $urandom); wdata = $urandom;
      st_pre = m_st; req_pre = req; m_ack = '0;
      if (!m_st) begin
        m_gnt = '0; found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (!found && req[j]) begin found = 1'b1; w = j; end
        end
        if (found) begin
          m_q = wdata[w*8 +: 8]; m_ack = 4'b0001 << w; m_gnt = m_ack; m_owner = w; m_qv = 1'b1;
          if (lock[w]) m_st = 1'b1; else m_ptr = (w + 1) % 4;
        end
      end else begin
        if (req[m_owner]) begin m_q = wdata[m_owner*8 +: 8]; m_ack = 4'b0001 << m_owner; end
        if (!lock[m_owner]) begin m_st = 1'b0; m_ptr = (m_owner + 1) % 4; m_gnt = '0; end
      end
      step();
      total++; if (q !== m_q) begin bad++; $display("FAIL rnd_q n=%0d got=%h exp=%h", n, q, m_q); end
      total++; if (ack !== m_ack) begin bad++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, ack, m_ack); end
      total++; if (gnt !== m_gnt) begin bad++; $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, gnt, m_gnt); end
      total++; if (owner !== 2'(m_owner) || qv !== m_qv) begin bad++; $display("FAIL rnd_owner n=%0d got=%0d/%b exp=%0d/%b", n, owner, qv, m_owner, m_qv); end
      total++; if (!$onehot0(gnt) || !$onehot0(ack)) begin bad++; $display("FAIL rnd_onehot n=%0d got=%b/%b exp=onehot0", n, gnt, ack); end
      if (!st_pre && req_pre != 4'b0) begin
        wmax = 0;
        for (int i = 0; i < 4; i++) begin
          wt[i] = (!req_pre[i] || ack[i]) ? 0 : wt[i] + 1;
          wmax = (wt[i] > wmax) ? wt[i] : wmax;
        end
        total++; if (wmax > 3) begin bad++; $display("FAIL rnd_fair n=%0d got=%0d exp<=3", n, wmax); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_sparse();
    test_lock_burst();
    test_own_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
